// File: rtl/ahb_split_slave.sv
// AHB word-storage slave that SPLITs masters without a release ticket and frees
// them one at a time (lowest index first) through HSPLIT after a fixed delay.
module ahb_split_slave #(
  parameter int unsigned SPLIT_DELAY = 8,
  parameter int unsigned MEM_WORDS   = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [3:0]  HMASTER,
  input  logic        HMASTLOCK,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [15:0] HSPLIT
);
  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [2:0] {IDLE, XFER, SPLIT1, SPLIT2, ERR1, ERR2} state_e;

  state_e         state_q, state_d;
  logic [15:0]    pending_q, pending_d, ready_q, ready_d, hsplit_q, hsplit_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic           write_q, write_d;
  logic [31:0]    mem_q [MEM_WORDS];

  logic           accept, release_now;
  logic [15:0]    mst_vec, rel_vec;
  logic [31:0]    word_sel;
  logic           unused_ok;

  assign word_sel    = {28'd0, HADDR[5:2]} % MEM_WORDS;
  assign unused_ok   = ^{HADDR[31:6], HADDR[1:0], HTRANS[0], word_sel[31:AW]};
  assign accept      = HSEL & HREADY & HTRANS[1];
  assign mst_vec     = 16'd1 << HMASTER;
  assign release_now = (pending_q != 16'd0) && (cnt_q == 8'd1);
  // Isolate the lowest pending master so only one HSPLIT bit can ever fire.
  assign rel_vec     = release_now ? (pending_q & (~pending_q + 16'd1)) : 16'd0;
  assign hsplit_d    = rel_vec;

  always_comb begin
    state_d   = IDLE;
    addr_d    = addr_q;
    write_d   = write_q;
    pending_d = pending_q & ~rel_vec;
    ready_d   = ready_q;
    case (state_q)
      SPLIT1:  state_d = SPLIT2;
      ERR1:    state_d = ERR2;
      default: begin
        if (accept) begin
          if (HSIZE != 3'b010) begin
            state_d = ERR1;
          end else if (HMASTLOCK || ready_q[HMASTER]) begin
            state_d = XFER;
            addr_d  = word_sel[AW-1:0];
            write_d = HWRITE;
            ready_d = ready_q & ~mst_vec;
          end else begin
            state_d   = SPLIT1;
            pending_d = pending_d | mst_vec;
          end
        end
      end
    endcase
    ready_d = ready_d | rel_vec;
    // Timer (re)starts only on empty->busy or after a release; re-splits don't restart it.
    if ((pending_q == 16'd0) || release_now)
      cnt_d = (pending_d != 16'd0) ? 8'(SPLIT_DELAY) : 8'd0;
    else
      cnt_d = cnt_q - 8'd1;
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 2'b00;
    case (state_q)
      SPLIT1:  begin HREADYOUT = 1'b0; HRESP = 2'b11; end
      SPLIT2:  HRESP = 2'b11;
      ERR1:    begin HREADYOUT = 1'b0; HRESP = 2'b01; end
      ERR2:    HRESP = 2'b01;
      default: ;
    endcase
  end

  assign HRDATA = (state_q == XFER && !write_q) ? mem_q[addr_q] : 32'd0;
  assign HSPLIT = hsplit_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= IDLE;
      pending_q <= 16'd0;
      ready_q   <= 16'd0;
      hsplit_q  <= 16'd0;
      cnt_q     <= 8'd0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      for (int i = 0; i < int'(MEM_WORDS); i++) mem_q[i] <= 32'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
      hsplit_q  <= hsplit_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      if (state_q == XFER && write_q) mem_q[addr_q] <= HWDATA;
    end
  end
endmodule

// File: tb/tb_ahb_split_slave.sv
// Randomized bench for ahb_split_slave against a response-queue / pending-set model.
module tb_ahb_split_slave;
  localparam int unsigned SPLIT_DELAY = 8;
  localparam int unsigned MEM_WORDS   = 16;

  logic        hclk = 1'b0;
  logic        hrst_n;
  logic        hsel, hwrite, hready, hmastlock;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans, hresp;
  logic [2:0]  hsize;
  logic [3:0]  hmaster;
  logic        hreadyout;
  logic [15:0] hsplit;

  always #5 hclk = ~hclk;
  assign hready = hreadyout;

  ahb_split_slave #(.SPLIT_DELAY(SPLIT_DELAY), .MEM_WORDS(MEM_WORDS)) dut (
    .HCLK(hclk), .HRESETn(hrst_n), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
    .HMASTER(hmaster), .HMASTLOCK(hmastlock), .HRDATA(hrdata),
    .HREADYOUT(hreadyout), .HRESP(hresp), .HSPLIT(hsplit)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: queue of upcoming data-phase beats plus the set of parked masters.
  typedef struct { bit rdy; bit [1:0] resp; bit wr; bit rd; int idx; } beat_t;
  beat_t     bq[$];
  bit [31:0] m_mem [MEM_WORDS];
  bit [15:0] m_pend, m_rdy, m_split_exp;
  int        m_timer;

  function automatic beat_t cur_beat();
    beat_t b;
    b.rdy = 1; b.resp = 2'b00; b.wr = 0; b.rd = 0; b.idx = 0;
    if (bq.size() > 0) b = bq[0];
    return b;
  endfunction

  function automatic void push(bit r, bit [1:0] rs, bit w, bit rd, int idx);
    beat_t b;
    b.rdy = r; b.resp = rs; b.wr = w; b.rd = rd; b.idx = idx;
    bq.push_back(b);
  endfunction

  function automatic void model_reset();
    bq.delete();
    for (int i = 0; i < int'(MEM_WORDS); i++) m_mem[i] = 0;
    m_pend = 0; m_rdy = 0; m_split_exp = 0; m_timer = 0;
  endfunction

  function automatic void model_update(bit sel, bit [1:0] trans, bit wr, bit [2:0] size,
                                       bit [31:0] addr, bit [3:0] mst, bit lock, bit [31:0] wd);
    beat_t     cb = cur_beat();
    bit        acc = sel && trans[1] && cb.rdy;
    bit [15:0] was = m_pend, rdy_old = m_rdy, rel = 0;
    if (cb.wr) m_mem[cb.idx] = wd;
    if (bq.size() > 0) void'(bq.pop_front());
    if (was != 0) begin
      m_timer--;
      if (m_timer == 0)
        for (int i = 0; i < 16; i++) if (was[i]) begin rel = 16'd1 << i; break; end
    end
    m_pend &= ~rel;
    m_split_exp = rel;
    if (acc) begin
      if (size != 3'b010) begin
        push(0, 2'b01, 0, 0, 0); push(1, 2'b01, 0, 0, 0);
      end else if (lock || rdy_old[mst]) begin
        m_rdy[mst] = 0;
        push(1, 2'b00, wr, !wr, int'(addr[5:2]) % int'(MEM_WORDS));
      end else begin
        m_pend[mst] = 1;
        push(0, 2'b11, 0, 0, 0); push(1, 2'b11, 0, 0, 0);
      end
    end
    m_rdy |= rel;
    if (m_pend == 0) m_timer = 0;
    else if (was == 0 || rel != 0) m_timer = SPLIT_DELAY;
  endfunction

  task automatic check_outputs();
    beat_t cb = cur_beat();
    chk("hreadyout", hreadyout, cb.rdy);
    chk("hresp", hresp, cb.resp);
    chk("hrdata", hrdata, cb.rd ? m_mem[cb.idx] : 32'd0);
    chk("hsplit", hsplit, m_split_exp);
    chk("hsplit_onehot", ($countones(hsplit) <= 1), 1);
  endtask

  task automatic step(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [2:0] size, input logic [31:0] addr, input logic [3:0] mst,
                      input logic lock, input logic [31:0] wd);
    hsel = sel; htrans = trans; hwrite = wr; hsize = size; haddr = addr;
    hmaster = mst; hmastlock = lock; hwdata = wd;
    model_update(sel, trans, wr, size, addr, mst, lock, wd);
    @(posedge hclk); #1;
    cyc++;
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 2'b00, 0, 3'b010, 32'd0, 4'd0, 0, $urandom);
  endtask

  task automatic do_reset(input int n);
    hrst_n = 0; hsel = 0; htrans = 2'b00;
    model_reset();
    #1;
    chk("rst_hreadyout", hreadyout, 1);
    chk("rst_hresp", hresp, 0);
    chk("rst_hrdata", hrdata, 0);
    chk("rst_hsplit", hsplit, 0);
    repeat (n) @(posedge hclk);
    #1;
    hrst_n = 1;
    check_outputs();
  endtask

  initial begin
    int c0, t2, t5;
    hrst_n = 1; hsel = 0; htrans = 0; hwrite = 0; hsize = 3'b010; haddr = 0;
    hwdata = 0; hmaster = 0; hmastlock = 0;
    model_reset();
    @(posedge hclk); #1;
    do_reset(3);

    // Master 3: split, release, write retry, then read back through its own split.
    step(1, 2'b10, 1, 3'b010, 32'h20, 4'd3, 0, $urandom);
    chk("r27_split1_rdy", hreadyout, 0); chk("r27_split1_resp", hresp, 2'b11);
    idle(1);
    chk("r27_split2_rdy", hreadyout, 1); chk("r27_split2_resp", hresp, 2'b11);
    for (int k = 2; k <= int'(SPLIT_DELAY); k++) idle(1);
    chk("r27_hsplit", hsplit, 16'h0008);
    idle(1);
    chk("r27_hsplit_off", hsplit, 16'h0000);
    step(1, 2'b10, 1, 3'b010, 32'h20, 4'd3, 0, $urandom);
    chk("r27_retry_rdy", hreadyout, 1); chk("r27_retry_resp", hresp, 2'b00);
    step(0, 2'b00, 0, 3'b010, 32'd0, 4'd0, 0, 32'hDEADBEEF);
    step(1, 2'b10, 0, 3'b010, 32'h20, 4'd3, 0, $urandom);
    chk("r27_rd_split", hresp, 2'b11);
    idle(SPLIT_DELAY + 1);
    step(1, 2'b10, 0, 3'b010, 32'h20, 4'd3, 0, $urandom);
    chk("r27_rd_resp", hresp, 2'b00); chk("r27_rdata", hrdata, 32'hDEADBEEF);
    idle(1);

    // Masters 2 and 5 split back to back: releases SPLIT_DELAY apart.
    step(1, 2'b10, 0, 3'b010, 32'h0, 4'd2, 0, $urandom);
    c0 = cyc;
    idle(1);
    step(1, 2'b10, 0, 3'b010, 32'h4, 4'd5, 0, $urandom);
    chk("r28_m5_split", hresp, 2'b11);
    t2 = -1000; t5 = -1000;
    for (int i = 0; i < 3 * int'(SPLIT_DELAY); i++) begin
      idle(1);
      if (hsplit == 16'h0004) t2 = cyc;
      if (hsplit == 16'h0020) t5 = cyc;
    end
    chk("r28_first", 32'(t2 - c0), SPLIT_DELAY);
    chk("r28_gap", 32'(t5 - t2), SPLIT_DELAY);

    // Bad size -> two-cycle ERROR, storage untouched (checked by locked read).
    step(1, 2'b10, 1, 3'b000, 32'h20, 4'd4, 0, $urandom);
    chk("r30_err1_rdy", hreadyout, 0); chk("r30_err1_resp", hresp, 2'b01);
    step(0, 2'b00, 0, 3'b010, 32'd0, 4'd0, 0, 32'h12345678);
    chk("r30_err2_rdy", hreadyout, 1); chk("r30_err2_resp", hresp, 2'b01);
    step(1, 2'b10, 0, 3'b010, 32'h20, 4'd7, 1, $urandom);
    chk("r29_lock_rdy", hreadyout, 1); chk("r29_lock_resp", hresp, 2'b00);
    chk("r30_unchanged", hrdata, 32'hDEADBEEF);
    idle(SPLIT_DELAY + 2);
    chk("r29_no_hsplit", hsplit, 16'h0000);

    // IDLE and BUSY while selected are zero-wait OKAY.
    step(1, 2'b00, 1, 3'b010, 32'h40, 4'd1, 0, $urandom);
    chk("r32_idle_rdy", hreadyout, 1); chk("r32_idle_resp", hresp, 2'b00);
    step(1, 2'b01, 0, 3'b010, 32'h40, 4'd1, 0, $urandom);
    chk("r32_busy_resp", hresp, 2'b00);

    // Reset at count 4 aborts the countdown; master 1 is split again afterwards.
    step(1, 2'b10, 0, 3'b010, 32'h8, 4'd1, 0, $urandom);
    idle(4);
    do_reset(2);
    idle(SPLIT_DELAY + 4);
    step(1, 2'b10, 0, 3'b010, 32'h8, 4'd1, 0, $urandom);
    chk("r31_resplit_rdy", hreadyout, 0); chk("r31_resplit_resp", hresp, 2'b11);
    idle(SPLIT_DELAY + 2);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset(2);
      else step($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b010,
                $urandom, 4'($urandom_range(0, 5)), $urandom_range(0, 15) == 0, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
